mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: LAT_CHECK, default 0, meaning 1 enables the assertion-only protocol checker.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request pulse; sampled on a rising edge of clk.
REQ-006 sgn  in  1  1 = MULT (signed), 0 = MULTU (unsigned); sampled with start.
REQ-007 a, b  in  32 each  operands; sampled with start.
REQ-008 busy  out  1  operation in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 hi, lo  out  32 each  product[63:32] and product[31:0].

Function
REQ-011 The FSM SHALL have states IDLE, MUL0, MUL1, MUL2, MUL3, SIGN and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; on acceptance the block latches |a|, |b| (signed mode, two's-complement magnitude; 0x80000000 -> 0x80000000 unsigned), latches neg = sgn & (a[31]^b[31]), clears the 64-bit accumulator and enters MUL0.
REQ-013 start in MUL0..SIGN SHALL be ignored with no side effect.
REQ-014 Each MULi state SHALL present one 16x16 half-pair to a single shared Multiplier instance and add the corrected partial product to the accumulator on the exiting edge.
REQ-015 Partial product order SHALL be: MUL0 al*bl <<0, MUL1 ah*bl <<16, MUL2 al*bh <<16, MUL3 ah*bh <<32.
REQ-016 Multiplier is signed, so the block SHALL form each unsigned product as U = S + (((x[15]?y:0) + (y[15]?x:0)) << 16) mod 2^32, where S is the Multiplier output.
REQ-017 The transition MUL3 -> SIGN SHALL be unconditional.
REQ-018 SIGN SHALL replace the accumulator with its 64-bit two's complement when neg=1 and leave it unchanged otherwise, then load hi/lo and go to DONE.
REQ-019 Latency SHALL be fixed: when start is sampled on edge E0, hi/lo update and done rises on E5; done stays high exactly one cycle.
REQ-020 DONE SHALL go to MUL0 if start is accepted and to IDLE otherwise; back-to-back operations therefore have 6-cycle throughput.
REQ-021 busy SHALL be 1 exactly in MUL0..SIGN.
REQ-022 hi/lo SHALL hold the last result until the next SIGN state; they SHALL NOT change during MUL0..MUL3.
REQ-023 All arithmetic SHALL be modulo 2^64, and no overflow or status flag SHALL be produced.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, accumulator=0 and neg=0.
REQ-025 Reset mid-operation SHALL abandon the operation without producing a done pulse, and no stale result SHALL appear after rst_n rises.
REQ-026 The first start SHALL be honoured on the first rising edge at which rst_n is high.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the MULT/MULTU sgn encodings and the partial-product shift constants (0, 16, 32).
REQ-028 Exactly one sub-module SHALL be instantiated: Multiplier (16x16 signed, combinational, 32-bit out), driven only from registered operand halves.
REQ-029 The correction adder, accumulator and negation SHALL live in mult_ctrl.

Verification
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> on E5 hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
REQ-031 MULT a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT a=b=0xFFFFFFFF -> hi=0, lo=1.
REQ-032 MULT a=b=0x80000000 -> hi=0x40000000, lo=0; MULTU a=0x00010000, b=0x0000FFFF -> hi=0, lo=0xFFFF0000.
REQ-033 Second start at E2 (busy) with a=b=5 -> ignored, first result only; start asserted in DONE with a=b=3 -> accepted, next done 6 cycles later, lo=9.
REQ-034 rst_n low at MUL2 -> hi=lo=0, busy=0 and no done; the next start with a=2, b=3 -> lo=6 at E5.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the multi-cycle 32x32 multiplier controller.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        SIGN = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic SGN_MULT  = 1'b1;
    localparam logic SGN_MULTU = 1'b0;

    localparam int unsigned PP_SH0 = 0;
    localparam int unsigned PP_SH1 = 16;
    localparam int unsigned PP_SH2 = 32;

    // Two's-complement magnitude; 0x80000000 maps onto itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Request/response bundle between a requester and mult_ctrl.
interface mult_ctrl_if;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, sgn, a, b, input busy, done, hi, lo);
    modport slave  (input start, sgn, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_ctrl_multiplier.sv
// Combinational 16x16 signed multiplier, 32-bit product.
module mult_ctrl_multiplier (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);
    assign p = 32'($signed(x)) * 32'($signed(y));
endmodule

// File: rtl/mult_ctrl.sv
// Sequential 32x32 MULT/MULTU built from four 16x16 partial products on one shared multiplier.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter bit LAT_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_ctrl_if.slave  bus
);

    state_t      state, nxt;
    logic        accept;
    logic [31:0] mag_a, mag_b, in_mag_a, in_mag_b;
    logic [15:0] opx, opy;
    logic        neg;
    logic [63:0] acc, pp, res;
    logic [31:0] prod, corr, uprod;
    logic [31:0] hi_q, lo_q;

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign in_mag_a = mag32(bus.a, bus.sgn == SGN_MULT);
    assign in_mag_b = mag32(bus.b, bus.sgn == SGN_MULT);

    mult_ctrl_multiplier u_mul (.x(opx), .y(opy), .p(prod));

    // Signed product -> unsigned: add back y*2^16 / x*2^16 for each negative-read half.
    assign corr  = ({16'b0, opy} & {32{opx[15]}}) + ({16'b0, opx} & {32{opy[15]}});
    assign uprod = prod + (corr << 16);
    assign res   = neg ? (~acc + 64'd1) : acc;

    always_comb begin
        pp = 64'd0;
        case (state)
            MUL0:       pp = {32'b0, uprod} << PP_SH0;
            MUL1, MUL2: pp = {32'b0, uprod} << PP_SH1;
            MUL3:       pp = {32'b0, uprod} << PP_SH2;
            default:    pp = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = MUL0;
            MUL0:    nxt = MUL1;
            MUL1:    nxt = MUL2;
            MUL2:    nxt = MUL3;
            MUL3:    nxt = SIGN;
            SIGN:    nxt = DONE;
            DONE:    nxt = accept ? MUL0 : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand halves are pre-loaded one state ahead so the multiplier sees only flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            opx   <= '0;
            opy   <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (accept) begin
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            opx   <= in_mag_a[15:0];
            opy   <= in_mag_b[15:0];
            neg   <= (bus.sgn == SGN_MULT) & (bus.a[31] ^ bus.b[31]);
            acc   <= '0;
        end else begin
            case (state)
                MUL0: begin
                    acc <= acc + pp;
                    opx <= mag_a[31:16];
                    opy <= mag_b[15:0];
                end
                MUL1: begin
                    acc <= acc + pp;
                    opx <= mag_a[15:0];
                    opy <= mag_b[31:16];
                end
                MUL2: begin
                    acc <= acc + pp;
                    opx <= mag_a[31:16];
                    opy <= mag_b[31:16];
                end
                MUL3: acc <= acc + pp;
                SIGN: begin
                    acc  <= res;
                    hi_q <= res[63:32];
                    lo_q <= res[31:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == MUL0) || (state == MUL1) || (state == MUL2) ||
                      (state == MUL3) || (state == SIGN);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    if (LAT_CHECK) begin : g_chk
        a_sign_done: assert property (@(posedge clk) disable iff (!rst_n)
                                      (state == SIGN) |=> bus.done);
        a_busy_done: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(bus.busy && bus.done));
        a_done_once: assert property (@(posedge clk) disable iff (!rst_n)
                                      bus.done |=> !bus.done);
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed checks of mult_ctrl: reset, signed/unsigned products, latency, busy-ignore, mid-op reset.
module tb_mult_ctrl;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] prev_hi, prev_lo;

    mult_ctrl_if bus ();

    mult_ctrl #(.LAT_CHECK(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives start now; the next edge is E0. Returns just after E5.
    task automatic run_op(input logic s, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        bus.start = 1'b1;
        bus.sgn   = s;
        bus.a     = ia;
        bus.b     = ib;
        cyc();
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
            chk({tag, "_early_done"}, {31'b0, bus.done}, 32'd0);
            chk({tag, "_hold_hi"}, bus.hi, prev_hi);
            chk({tag, "_hold_lo"}, bus.lo, prev_lo);
            cyc();
        end
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    task automatic after_done(input string tag);
        cyc();
        chk({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_busy_idle"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        prev_hi   = '0;
        prev_lo   = '0;

        #12;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        // Start is presented with reset release so the very first high edge must take it.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        after_done("multu_max");

        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7xm3");
        after_done("mult_7xm3");
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1");
        after_done("mult_m1");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min");
        after_done("mult_min");
        run_op(1'b0, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_0000, "multu_mix");
        after_done("multu_mix");
        run_op(1'b1, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h4000_0000, "mult_bit15");
        after_done("mult_bit15");

        // Start during busy (sampled at E2) must be ignored.
        bus.start = 1'b1;
        bus.sgn   = 1'b0;
        bus.a     = 32'd10;
        bus.b     = 32'd20;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        chk("ign_busy", {31'b0, bus.busy}, 32'd1);
        cyc();
        chk("ign_done", {31'b0, bus.done}, 32'd1);
        chk("ign_hi", bus.hi, 32'd0);
        chk("ign_lo", bus.lo, 32'd200);
        prev_hi = 32'd0;
        prev_lo = 32'd200;

        // Start while in DONE is accepted; next done 6 cycles later.
        run_op(1'b0, 32'd3, 32'd3, 32'd0, 32'd9, "b2b");
        after_done("b2b");

        // Reset in MUL2 abandons the operation.
        bus.start = 1'b1;
        bus.sgn   = 1'b0;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mrst_hi", bus.hi, 32'd0);
        chk("mrst_lo", bus.lo, 32'd0);
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_done", {31'b0, bus.done}, 32'd0);
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("mrst_no_done", {31'b0, bus.done}, 32'd0);
            chk("mrst_no_stale", bus.lo, 32'd0);
        end
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, "post_rst");
        after_done("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
